// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter on the core IO port.
// A store to a word address with bit 1 set enqueues io_wdata[7:0]; the byte
// is serialised LSB first (start bit, 8 data bits, stop bit) on txd.
// The status word on io_rdata is {21'b0, ovf, full, busy, count[7:0]}.
//
// Optional macro UART_TX_FIFO_EN:
//   defined   - FIFO_DEPTH-entry TX FIFO (power of 2, 2..128).
//   undefined - a single holding register (effective depth 1); FIFO_DEPTH
//               is ignored.
module io_uart_tx #(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_wr,
  input  logic [13:0] io_wordaddr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        txd,
  output logic        busy
);

  // Bit period in clock cycles; the baud counter runs DIV-1 down to 0.
  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(DIV - 1);

`ifdef UART_TX_FIFO_EN
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int DEPTH = FIFO_DEPTH;
`else
  localparam int CW    = 1;
  localparam int DEPTH = 1;
  localparam int unused_fifo_depth = FIFO_DEPTH;
`endif
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Control state
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          txd_q, txd_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  // Datapath state (not reset: only ever observed under control gating)
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    head;

  // Handshake between the IO write decode, the buffer and the FSM
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          full;
  logic          fifo_nonempty;
  logic [7:0]    count8;

  // Bits of the IO bus this block never looks at.
  logic unused_io;
  assign unused_io = ^{io_wdata[31:8], io_wordaddr[13:2], io_wordaddr[0]};

  // ---------------------------------------------------------------------
  // Write decode and buffer flags. A push into a full buffer still lands
  // when the FSM pops in the same cycle, because the slot frees up at the
  // same edge. Pop depends only on registered state, so there is no
  // combinational loop through push_ok.
  // ---------------------------------------------------------------------
  assign push_req      = io_wr & io_wordaddr[1];
  assign full          = (count_q == COUNT_FULL);
  assign fifo_nonempty = (count_q != '0);
  assign push_ok       = push_req & (~full | pop);
  assign ovf_d         = ovf_q | (push_req & ~push_ok);

  // Occupancy tracks accepted pushes minus pops; the shifter is not counted.
  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef UART_TX_FIFO_EN
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;

  // Read/write pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop)     rptr_q <= rptr_q + AW'(1);
    end
  end

  // Storage array; a same-cycle pop reads the old head before it is reused.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= io_wdata[7:0];
  end

  assign head = mem_q[rptr_q];
`else
  logic [7:0] hold_q;

  // Single holding register standing in for the FIFO.
  always_ff @(posedge clk) begin
    if (push_ok) hold_q <= io_wdata[7:0];
  end

  assign head = hold_q;
`endif

  // ---------------------------------------------------------------------
  // Transmit FSM. Every state lasts DIV cycles (DATA lasts DIV per bit).
  // A byte waiting at the end of STOP is popped straight into START so
  // that back-to-back frames have no idle gap.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = BAUD_RELOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      S_STOP: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level follows the state being entered, so txd is a clean register.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // Control registers; reset drops any in-flight byte and flushes the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      txd_q   <= 1'b1;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Shift register for the byte on the wire.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // ---------------------------------------------------------------------
  // Outputs. Status is address decode plus registered flags only, so it
  // is ready for the core to sample one cycle after the address.
  // ---------------------------------------------------------------------
  assign count8   = 8'(count_q);
  assign busy     = (state_q != S_IDLE) | fifo_nonempty;
  assign txd      = txd_q;
  assign io_rdata = io_wordaddr[1] ? {21'b0, ovf_q, full, busy, count8} : 32'b0;

endmodule
